// File: rtl/fetch_pkg.sv
// Shared types and helpers for the RV32 instruction-fetch front end.
package fetch_pkg;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Sign-extended J-type immediate.
    function automatic logic [31:0] jal_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; used as the instruction
// buffer and as the in-flight request address queue.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count != FULL) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction-fetch front end: credit-limited requests, in-order response
// buffering, external redirects. Define FETCH_JAL_PREDECODE_EN for early JAL redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BUF_DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int CNT_W = cnt_width(BUF_DEPTH);
    localparam int OCC_W = CNT_W + 1;

    logic [31:0]      r_fpc;
    logic [CNT_W-1:0] r_drop_cnt;
    fetch_entry_t     r_last;

    logic [31:0]      w_fpc_next;
    logic [CNT_W-1:0] w_drop_next;
    logic [CNT_W-1:0] w_buf_count;
    logic [CNT_W-1:0] w_aq_count;
    logic [CNT_W-1:0] w_out_after;
    logic [OCC_W-1:0] w_occ;
    logic [31:0]      w_aq_head;
    logic [31:0]      w_jal_target;
    fetch_entry_t     w_buf_head;
    fetch_entry_t     w_buf_in;
    logic             w_req_fire;
    logic             w_inst_pop;
    logic             w_rsp_keep;
    logic             w_buf_push;
    logic             w_jal_hit;

    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_inst_pop = inst_valid & inst_ready;
    assign w_rsp_keep = imem_rsp_valid & (r_drop_cnt == '0);
    assign w_buf_push = w_rsp_keep & ~redirect_valid;
    assign w_buf_in   = '{pc: w_aq_head, data: imem_rsp_data};

    // A slot freed by this cycle's decode handshake is reusable immediately,
    // which is what sustains one instruction per cycle at BUF_DEPTH=2.
    assign w_occ = OCC_W'(w_buf_count) + OCC_W'(w_aq_count) - OCC_W'(w_inst_pop);
    assign imem_req_valid = reset & (w_occ < OCC_W'(BUF_DEPTH));
    assign imem_req_addr  = r_fpc;

    assign w_out_after  = w_aq_count + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);
    assign w_jal_target = (w_aq_head + jal_imm(imem_rsp_data)) & 32'hFFFF_FFFC;

`ifdef FETCH_JAL_PREDECODE_EN
    assign w_jal_hit = w_buf_push & (imem_rsp_data[6:0] == OPC_JAL);
`else
    assign w_jal_hit = 1'b0;
`endif

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_addr_q (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_req_fire),
        .i_data  (r_fpc),
        .i_pop   (imem_rsp_valid),
        .i_flush (1'b0),
        .o_head  (w_aq_head),
        .o_count (w_aq_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_inst_buf (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_buf_push),
        .i_data  (w_buf_in),
        .i_pop   (w_inst_pop),
        .i_flush (redirect_valid),
        .o_head  (w_buf_head),
        .o_count (w_buf_count)
    );

    // Priority: external redirect > predecoded JAL > sequential advance.
    always_comb begin
        w_fpc_next  = r_fpc;
        w_drop_next = r_drop_cnt;
        if (w_req_fire) w_fpc_next = r_fpc + 32'd4;
        if (imem_rsp_valid && (r_drop_cnt != '0)) w_drop_next = r_drop_cnt - CNT_W'(1);
        if (w_jal_hit) begin
            w_fpc_next  = w_jal_target;
            w_drop_next = w_out_after;
        end
        if (redirect_valid) begin
            w_fpc_next  = redirect_pc & 32'hFFFF_FFFC;
            w_drop_next = w_out_after;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fpc      <= RESET_VECTOR;
            r_drop_cnt <= '0;
            r_last     <= '0;
        end else begin
            r_fpc      <= w_fpc_next;
            r_drop_cnt <= w_drop_next;
            if (inst_valid) r_last <= w_buf_head;
        end
    end

    assign inst_valid = (w_buf_count != '0);
    assign inst_data  = inst_valid ? w_buf_head.data : r_last.data;
    assign inst_pc    = inst_valid ? w_buf_head.pc   : r_last.pc;

endmodule
